// File: rtl/axis_dsnk_seq.sv
// axis_dsnk_seq: run sequencer for the AXI-Stream data sink.
// It issues reset/enable/stop commands to the sink and watches recv_bytes
// against a byte target and a RUN-cycle timeout. After a drain period it
// captures the final byte count and checksum into result registers.
module axis_dsnk_seq #(
  parameter int unsigned C_SETTLE_CYCLES = 2,
  parameter int unsigned C_DRAIN_CYCLES  = 4
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_RESET,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] target_bytes,
  input  logic [31:0] timeout_cycles,
  output logic [31:0] cmd,
  output logic        new_cmd,
  input  logic [31:0] stat,
  input  logic [31:0] recv_bytes,
  input  logic [63:0] checksum,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic        aborted,
  output logic [31:0] result_bytes,
  output logic [63:0] result_checksum
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned CMD_W = 32;

  localparam logic [CMD_W-1:0] CMD_ENABLE = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_RESET  = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_STOP   = CMD_W'(3);

  // Last count value of each wait state; a zero-length drain collapses to one cycle.
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    (C_SETTLE_CYCLES > 0) ? CNT_W'(C_SETTLE_CYCLES - 1) : CNT_W'(0);
  localparam logic [CNT_W-1:0] DRAIN_LAST =
    (C_DRAIN_CYCLES > 0) ? CNT_W'(C_DRAIN_CYCLES - 1) : CNT_W'(0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_EN      = 3'd3,
    ST_RUN     = 3'd4,
    ST_STOP    = 3'd5,
    ST_DRAIN   = 3'd6,
    ST_CAPTURE = 3'd7
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [31:0]       target_q;
  logic [31:0]       timeout_q;
  logic              hit_target_c;
  logic              hit_timeout_c;

  // Sink status is informational only; the sequencer runs purely on its own timing.
  logic stat_unused;
  assign stat_unused = ^stat;

  // Saturating counter increment and RUN exit conditions.
  always_comb begin
    cnt_d         = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    hit_target_c  = (target_q != 32'd0) && (recv_bytes >= target_q);
    hit_timeout_c = (timeout_q != 32'd0) && (cnt_q == timeout_q - 32'd1);
  end

  // Sequencer FSM with registered command, status and result outputs.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_RESET) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      target_q        <= '0;
      timeout_q       <= '0;
      cmd             <= '0;
      new_cmd         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      timed_out       <= 1'b0;
      aborted         <= 1'b0;
      result_bytes    <= '0;
      result_checksum <= '0;
    end else begin
      new_cmd <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            target_q  <= target_bytes;
            timeout_q <= timeout_cycles;
            timed_out <= 1'b0;
            aborted   <= 1'b0;
            busy      <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_RST;
          end
        end

        ST_RST: begin
          if (abort) begin
            aborted <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            cmd     <= CMD_RESET;
            new_cmd <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            aborted <= 1'b1;
            state_q <= ST_STOP;
          end else if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_EN;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_EN: begin
          if (abort) begin
            aborted <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            cmd     <= CMD_ENABLE;
            new_cmd <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          cnt_q <= cnt_d;
          if (abort) begin
            aborted <= 1'b1;
            state_q <= ST_STOP;
          end else if (hit_target_c) begin
            state_q <= ST_STOP;
          end else if (hit_timeout_c) begin
            timed_out <= 1'b1;
            state_q   <= ST_STOP;
          end
        end

        ST_STOP: begin
          cmd     <= CMD_STOP;
          new_cmd <= 1'b1;
          cnt_q   <= '0;
          state_q <= ST_DRAIN;
        end

        ST_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_CAPTURE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_CAPTURE: begin
          result_bytes    <= recv_bytes;
          result_checksum <= checksum;
          done            <= 1'b1;
          busy            <= 1'b0;
          state_q         <= ST_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_dsnk_seq.sv
// Directed bench for axis_dsnk_seq with a small behavioural model of the sink.
module tb_axis_dsnk_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] target_bytes = '0;
  logic [31:0] timeout_cycles = '0;
  logic [31:0] cmd;
  logic        new_cmd;
  logic [31:0] stat;
  logic [31:0] recv_bytes;
  logic [63:0] checksum;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic        aborted;
  logic [31:0] result_bytes;
  logic [63:0] result_checksum;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned done_cyc = 0;
  int          done_cnt = 0;
  logic [31:0] cmd_log[$];
  int unsigned cyc_log[$];

  // Sink model: 4-byte beats while enabled and fed; checksum adds (bytes_before + 1) per beat.
  logic        feed = 1'b0;
  logic [31:0] sink_bytes;
  logic [63:0] sink_csum;
  logic        sink_en;

  assign recv_bytes = sink_bytes;
  assign checksum   = sink_csum;
  assign stat       = {30'd0, 1'b0, sink_en};

  axis_dsnk_seq dut (
    .AXIS_ACLK       (clk),
    .AXIS_RESET      (rst),
    .start           (start),
    .abort           (abort),
    .target_bytes    (target_bytes),
    .timeout_cycles  (timeout_cycles),
    .cmd             (cmd),
    .new_cmd         (new_cmd),
    .stat            (stat),
    .recv_bytes      (recv_bytes),
    .checksum        (checksum),
    .busy            (busy),
    .done            (done),
    .timed_out       (timed_out),
    .aborted         (aborted),
    .result_bytes    (result_bytes),
    .result_checksum (result_checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      sink_bytes <= '0;
      sink_csum  <= '0;
      sink_en    <= 1'b0;
    end else if (new_cmd) begin
      case (cmd)
        32'd2: begin
          sink_bytes <= '0;
          sink_csum  <= '0;
          sink_en    <= 1'b0;
        end
        32'd1: sink_en <= 1'b1;
        32'd3: sink_en <= 1'b0;
        default: ;
      endcase
    end else if (sink_en && feed) begin
      sink_bytes <= sink_bytes + 32'd4;
      sink_csum  <= sink_csum + 64'(sink_bytes) + 64'd1;
    end
  end

  // Command strobe and done pulse monitor, sampled just after the clock edge.
  always @(posedge clk) begin
    #1;
    if (new_cmd) begin
      cmd_log.push_back(cmd);
      cyc_log.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_start(input logic [31:0] tgt, input logic [31:0] to);
    @(negedge clk);
    cmd_log.delete();
    cyc_log.delete();
    done_cnt       = 0;
    target_bytes   = tgt;
    timeout_cycles = to;
    start          = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < int'(max_cyc) && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_new_cmd", 64'(new_cmd), 64'd0);
    check("rst_cmd", 64'(cmd), 64'd0);
    check("rst_timed_out", 64'(timed_out), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    check("rst_result_bytes", 64'(result_bytes), 64'd0);
    check("rst_result_csum", result_checksum, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Target run: 64 bytes, continuous beats
    feed = 1'b1;
    run_start(32'd64, 32'd0);
    check("tgt_busy", 64'(busy), 64'd1);
    wait_done(200);
    check("tgt_ncmd", 64'(cmd_log.size()), 64'd3);
    check("tgt_cmd0", 64'(cmd_log[0]), 64'd2);
    check("tgt_cmd1", 64'(cmd_log[1]), 64'd1);
    check("tgt_cmd2", 64'(cmd_log[2]), 64'd3);
    check("tgt_rst_lat", 64'(cyc_log[0] - start_cyc), 64'd1);
    check("tgt_en_lat", 64'(cyc_log[1] - start_cyc), 64'd4);
    check("tgt_stop_lat", 64'(cyc_log[2] - start_cyc), 64'd23);
    check("tgt_done_lat", 64'(done_cyc - start_cyc), 64'd28);
    check("tgt_done_cnt", 64'(done_cnt), 64'd1);
    check("tgt_bytes_range", 64'(result_bytes >= 32'd64 && result_bytes <= 32'd72), 64'd1);
    check("tgt_bytes", 64'(result_bytes), 64'd72);
    check("tgt_csum", result_checksum, 64'd630);
    check("tgt_timed_out", 64'(timed_out), 64'd0);
    check("tgt_aborted", 64'(aborted), 64'd0);
    check("tgt_busy_end", 64'(busy), 64'd0);

    // Abort during SETTLE: reset and stop commands only
    run_start(32'd64, 32'd0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(100);
    check("abs_ncmd", 64'(cmd_log.size()), 64'd2);
    check("abs_cmd0", 64'(cmd_log[0]), 64'd2);
    check("abs_cmd1", 64'(cmd_log[1]), 64'd3);
    check("abs_stop_lat", 64'(cyc_log[1] - start_cyc), 64'd3);
    check("abs_aborted", 64'(aborted), 64'd1);
    check("abs_timed_out", 64'(timed_out), 64'd0);
    check("abs_bytes", 64'(result_bytes), 64'd0);

    // Timeout 50 with no data: 50 RUN cycles plus the stop issue cycle
    feed = 1'b0;
    run_start(32'd1000, 32'd50);
    wait_done(200);
    check("to50_ncmd", 64'(cmd_log.size()), 64'd3);
    check("to50_run_len", 64'(cyc_log[2] - cyc_log[1]), 64'd51);
    check("to50_timed_out", 64'(timed_out), 64'd1);
    check("to50_aborted", 64'(aborted), 64'd0);
    check("to50_bytes", 64'(result_bytes), 64'd0);
    check("to50_csum", result_checksum, 64'd0);

    // Shortest timeout: a single RUN cycle
    run_start(32'd0, 32'd1);
    wait_done(100);
    check("to1_run_len", 64'(cyc_log[2] - cyc_log[1]), 64'd2);
    check("to1_timed_out", 64'(timed_out), 64'd1);

    // Target reached on the timeout cycle: target wins
    feed = 1'b1;
    run_start(32'd32, 32'd10);
    wait_done(100);
    check("sim_run_len", 64'(cyc_log[2] - cyc_log[1]), 64'd11);
    check("sim_timed_out", 64'(timed_out), 64'd0);
    check("sim_bytes", 64'(result_bytes), 64'd40);
    check("sim_csum", result_checksum, 64'd190);

    // Target one beat beyond reach on the timeout cycle: timeout wins
    run_start(32'd36, 32'd10);
    wait_done(100);
    check("late_run_len", 64'(cyc_log[2] - cyc_log[1]), 64'd11);
    check("late_timed_out", 64'(timed_out), 64'd1);
    check("late_bytes", 64'(result_bytes), 64'd40);

    // start while busy in RUN is ignored and the latched target stands
    run_start(32'd64, 32'd0);
    repeat (9) @(negedge clk);
    target_bytes   = 32'd8;
    timeout_cycles = 32'd5;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    check("sb_ncmd", 64'(cmd_log.size()), 64'd3);
    check("sb_stop_lat", 64'(cyc_log[2] - start_cyc), 64'd23);
    check("sb_bytes", 64'(result_bytes), 64'd72);
    check("sb_timed_out", 64'(timed_out), 64'd0);
    check("sb_done_cnt", 64'(done_cnt), 64'd1);

    // Reset mid-RUN clears everything and issues no stop
    run_start(32'd0, 32'd0);
    repeat (10) @(negedge clk);
    check("mr_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_new_cmd", 64'(new_cmd), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_result_bytes", 64'(result_bytes), 64'd0);
    check("mr_result_csum", result_checksum, 64'd0);
    check("mr_timed_out", 64'(timed_out), 64'd0);
    check("mr_aborted", 64'(aborted), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mr_no_stop", 64'(cmd_log.size()), 64'd2);
    check("mr_idle", 64'(busy), 64'd0);

    // Fresh run after the mid-run reset
    run_start(32'd16, 32'd0);
    wait_done(100);
    check("fr_ncmd", 64'(cmd_log.size()), 64'd3);
    check("fr_bytes", 64'(result_bytes), 64'd24);
    check("fr_csum", result_checksum, 64'd66);
    check("fr_timed_out", 64'(timed_out), 64'd0);

    // No target, no timeout: only abort ends the run
    feed = 1'b0;
    run_start(32'd0, 32'd0);
    repeat (40) @(negedge clk);
    check("ab_still_busy", 64'(busy), 64'd1);
    check("ab_ncmd_mid", 64'(cmd_log.size()), 64'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(100);
    check("ab_cmd2", 64'(cmd_log[2]), 64'd3);
    check("ab_aborted", 64'(aborted), 64'd1);
    check("ab_timed_out", 64'(timed_out), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/axis_dsnk_seq.md
Name: axis_dsnk_seq

Overview:
Run sequencer for the AXI-Stream data sink used in the vita49_unpack simulation benches. It issues the sink's command words (reset, enable, stop) over the sink's cmd/new_cmd interface and monitors recv_bytes against a byte target and a cycle timeout. After the run it drains and captures the final byte count and checksum into result registers. A bench needs only start/done instead of hand-timing commands.

Parameters:
C_SETTLE_CYCLES, 2, cycles waited after the reset command before enable; must be >=2 so the sink counter clear has landed.
C_DRAIN_CYCLES, 4, cycles waited after the stop command before the result capture.

Ports:
AXIS_ACLK  in  1  single clock for all logic; the sink's control and data clocks are tied to it.
AXIS_RESET  in  1  synchronous, active-high reset.
start  in  1  one-cycle run request; ignored unless the block is in IDLE.
abort  in  1  level; forces an early stop.
target_bytes  in  32  byte target, latched on start; 0 means no target (run until timeout or abort).
timeout_cycles  in  32  RUN-state cycle limit, latched on start; 0 means no timeout.
cmd  out  32  command word to the sink.
new_cmd  out  1  one-cycle command strobe to the sink.
stat  in  32  sink status; bit0 = enable, bit1 = done.
recv_bytes  in  32  sink byte counter.
checksum  in  64  sink checksum.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when results are valid.
timed_out  out  1  sticky result flag: run ended by timeout.
aborted  out  1  sticky result flag: run ended by abort.
result_bytes  out  32  recv_bytes captured at the end of drain.
result_checksum  out  64  checksum captured at the end of drain.

Behaviour:
- Reset: state=IDLE; cmd=0; new_cmd=0; busy=0; done=0; timed_out=0; aborted=0; result_bytes=0; result_checksum=0; internal counters=0. A reset mid-run returns to IDLE immediately and issues no stop command; the bench must also reset the sink.
- Command issue: cmd is driven with the code and new_cmd=1 for exactly one cycle in that state. cmd keeps its value afterwards; new_cmd returns to 0. Codes: 2 = reset, 1 = enable, 3 = stop.
- IDLE: on start=1, latch target/timeout, clear timed_out/aborted, go to RST. busy rises the cycle after start.
- RST: issue 2 -> SETTLE.
- SETTLE: count C_SETTLE_CYCLES cycles -> EN.
- EN: issue 1 -> RUN. The cycle counter clears here.
- RUN: cycle counter increments every cycle. Exits are evaluated in priority order, and the highest-priority true condition wins:
  1. abort -> set aborted, go to STOP.
  2. target_bytes!=0 and recv_bytes>=target_bytes (unsigned) -> STOP.
  3. timeout_cycles!=0 and counter==timeout_cycles-1 -> set timed_out, go to STOP.
  - Result: a run lasts exactly timeout_cycles RUN cycles on timeout.
  - If target and timeout are hit in the same cycle, timed_out stays 0.
  - If target=0 and timeout=0, only abort ends the run.
- Abort during RST/SETTLE/EN: set aborted, go straight to STOP. The enable command is never issued after abort.
- STOP: issue 3 -> DRAIN.
- DRAIN: count C_DRAIN_CYCLES cycles, then go to CAPTURE.
- CAPTURE: result_bytes<=recv_bytes; result_checksum<=checksum; done=1 next cycle; return to IDLE.
- Result registers and flags hold until the next start.
- start while busy is ignored. start in the same cycle as done is accepted, because the block is then in IDLE.
- The counter is 32-bit and saturates; it never wraps within a run.
- Overshoot: the sink adds the bus width per beat, so result_bytes may exceed target by up to one beat plus beats accepted before stop lands. This is expected, not an error.
- Latency from start to the first enable strobe: 2 + C_SETTLE_CYCLES cycles.

Test Plan:
- Target run: target=64, timeout=0, sink fed continuous 4-byte beats -> cmd sequence 2,1,3 each with a single-cycle strobe; done pulses once; result_bytes in 64..72; timed_out=0; aborted=0.
- Timeout: target=1000, timeout=50, no TVALID -> stop is issued after exactly 50 RUN cycles; timed_out=1; result_bytes=0; result_checksum=0.
- Abort during SETTLE: abort=1 -> new_cmd strobes only for 2 and then 3, never for 1; aborted=1; result_bytes=0.
- Simultaneous end: recv_bytes reaches target on the same cycle the timeout expires -> timed_out=0.
- start while busy pulsed mid-RUN -> no state change; latched target unchanged.
- AXIS_RESET asserted mid-RUN -> next cycle: busy=0, new_cmd=0, all results zero; a fresh start then completes normally.
